// File: rtl/multi_color_tracker_if.sv
// Pixel stream, rule configuration and per-target result signals of the colour tracker.
interface multi_color_tracker_if #(
  parameter int NUM_TARGETS = 2,
  parameter int COORD_W     = 12,
  parameter int CNT_W       = 20
);
  logic                           in_valid;
  logic                           in_ready;
  logic [23:0]                    in_pixel;
  logic                           out_valid;
  logic                           out_ready;
  logic [23:0]                    out_pixel;
  logic                           cfg_wr_en;
  logic [1:0]                     cfg_idx;
  logic [10:0]                    cfg_data;
  logic                           frame_valid;
  logic [NUM_TARGETS-1:0]         found;
  logic [NUM_TARGETS*COORD_W-1:0] center_x;
  logic [NUM_TARGETS*COORD_W-1:0] center_y;
  logic [NUM_TARGETS*COORD_W-1:0] width;
  logic [NUM_TARGETS*COORD_W-1:0] height;
  logic [NUM_TARGETS*CNT_W-1:0]   pix_count;

  modport slave (
    input  in_valid, in_pixel, out_ready, cfg_wr_en, cfg_idx, cfg_data,
    output in_ready, out_valid, out_pixel, frame_valid, found,
           center_x, center_y, width, height, pix_count
  );

  modport master (
    output in_valid, in_pixel, out_ready, cfg_wr_en, cfg_idx, cfg_data,
    input  in_ready, out_valid, out_pixel, frame_valid, found,
           center_x, center_y, width, height, pix_count
  );
endinterface

// File: rtl/multi_color_tracker.sv
// Streaming multi-target colour classifier: per-target bounding box and pixel count per frame,
// with square markers from the previous frame's results overlaid on the pass-through stream.
module multi_color_tracker #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int NUM_TARGETS = 2,
  parameter int COORD_W     = 12,
  parameter int CNT_W       = 20,
  parameter int MARK_RADIUS = 3,
  parameter int MIN_PIXELS  = 16
) (
  input  logic                 clock_50,
  input  logic                 reset,
  multi_color_tracker_if.slave bus
);
  localparam logic [COORD_W-1:0]      LAST_X = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0]      LAST_Y = COORD_W'(HEIGHT - 1);
  localparam logic signed [COORD_W:0] RAD_P  = (COORD_W + 1)'(MARK_RADIUS);
  localparam logic signed [COORD_W:0] RAD_N  = -RAD_P;

  logic [COORD_W-1:0]     r_x;
  logic [COORD_W-1:0]     r_y;
  logic                   r_out_valid;
  logic [23:0]            r_out_pixel;
  logic                   r_frame_valid;
  logic                   w_accept;
  logic                   w_first;
  logic                   w_eof;
  logic [NUM_TARGETS-1:0] w_mark;
  logic [23:0]            w_ovl;

  function automatic logic [23:0] mark_colour(input int idx);
    case (idx)
      0:       return 24'hFF0000;
      1:       return 24'h0000FF;
      2:       return 24'hFFFF00;
      default: return 24'hFF00FF;
    endcase
  endfunction

  assign bus.in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_first      = w_accept & (r_x == '0) & (r_y == '0);
  assign w_eof        = w_accept & (r_x == LAST_X) & (r_y == LAST_Y);

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (r_x == LAST_X) begin
        r_x <= '0;
        r_y <= (r_y == LAST_Y) ? '0 : r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_tgt
    logic [10:0]             r_shadow;
    logic [10:0]             r_rule;
    logic [10:0]             w_shadow_next;
    logic [10:0]             w_rule;
    logic [7:0]              w_dom;
    logic [7:0]              w_oth_a;
    logic [7:0]              w_oth_b;
    logic                    w_chan_ok;
    logic                    w_match;
    logic                    w_hit;
    logic [COORD_W-1:0]      r_min_x, r_max_x, r_min_y, r_max_y;
    logic [COORD_W-1:0]      w_min_x, w_max_x, w_min_y, w_max_y;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt;
    logic                    w_found;
    logic [COORD_W:0]        w_sum_x;
    logic [COORD_W:0]        w_sum_y;
    logic                    r_found;
    logic [COORD_W-1:0]      r_cx, r_cy, r_w, r_h;
    logic [CNT_W-1:0]        r_pix;
    logic signed [COORD_W:0] w_dx;
    logic signed [COORD_W:0] w_dy;

    // The rule set switches at the first pixel of a frame, including a write landing in that cycle.
    assign w_shadow_next = (bus.cfg_wr_en && (bus.cfg_idx == 2'(gi))) ? bus.cfg_data : r_shadow;
    assign w_rule        = w_first ? w_shadow_next : r_rule;

    always_comb begin
      w_dom     = '0;
      w_oth_a   = '0;
      w_oth_b   = '0;
      w_chan_ok = 1'b1;
      case (w_rule[9:8])
        2'd0: begin
          w_dom   = bus.in_pixel[23:16];
          w_oth_a = bus.in_pixel[15:8];
          w_oth_b = bus.in_pixel[7:0];
        end
        2'd1: begin
          w_dom   = bus.in_pixel[15:8];
          w_oth_a = bus.in_pixel[23:16];
          w_oth_b = bus.in_pixel[7:0];
        end
        2'd2: begin
          w_dom   = bus.in_pixel[7:0];
          w_oth_a = bus.in_pixel[23:16];
          w_oth_b = bus.in_pixel[15:8];
        end
        default: w_chan_ok = 1'b0;
      endcase
    end

    assign w_match = w_rule[10] & w_chan_ok & (w_dom >= w_rule[7:0]) &
                     (w_oth_a <= {1'b0, w_dom[7:1]}) & (w_oth_b <= {1'b0, w_dom[7:1]});
    assign w_hit   = w_accept & w_match;

    assign w_min_x = (w_hit && (r_x < r_min_x)) ? r_x : r_min_x;
    assign w_max_x = (w_hit && (r_x > r_max_x)) ? r_x : r_max_x;
    assign w_min_y = (w_hit && (r_y < r_min_y)) ? r_y : r_min_y;
    assign w_max_y = (w_hit && (r_y > r_max_y)) ? r_y : r_max_y;
    assign w_cnt   = (w_hit && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

    assign w_found = w_rule[10] & (w_cnt >= CNT_W'(MIN_PIXELS));
    assign w_sum_x = {1'b0, w_min_x} + {1'b0, w_max_x};
    assign w_sum_y = {1'b0, w_min_y} + {1'b0, w_max_y};

    always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
        r_shadow <= '0;
        r_rule   <= '0;
        r_min_x  <= '1;
        r_max_x  <= '0;
        r_min_y  <= '1;
        r_max_y  <= '0;
        r_cnt    <= '0;
        r_found  <= 1'b0;
        r_cx     <= '0;
        r_cy     <= '0;
        r_w      <= '0;
        r_h      <= '0;
        r_pix    <= '0;
      end else begin
        r_shadow <= w_shadow_next;
        r_rule   <= w_rule;
        if (w_eof) begin
          r_min_x <= '1;
          r_max_x <= '0;
          r_min_y <= '1;
          r_max_y <= '0;
          r_cnt   <= '0;
          r_found <= w_found;
          r_cx    <= w_found ? w_sum_x[COORD_W:1] : '0;
          r_cy    <= w_found ? w_sum_y[COORD_W:1] : '0;
          r_w     <= w_found ? (w_max_x - w_min_x + COORD_W'(1)) : '0;
          r_h     <= w_found ? (w_max_y - w_min_y + COORD_W'(1)) : '0;
          r_pix   <= w_found ? w_cnt : '0;
        end else begin
          r_min_x <= w_min_x;
          r_max_x <= w_max_x;
          r_min_y <= w_min_y;
          r_max_y <= w_max_y;
          r_cnt   <= w_cnt;
        end
      end
    end

    // One extra sign bit keeps the distance test from wrapping near the frame edges.
    assign w_dx = $signed({1'b0, r_x}) - $signed({1'b0, r_cx});
    assign w_dy = $signed({1'b0, r_y}) - $signed({1'b0, r_cy});
    assign w_mark[gi] = r_found & (w_dx >= RAD_N) & (w_dx <= RAD_P) &
                        (w_dy >= RAD_N) & (w_dy <= RAD_P);

    assign bus.found[gi]                          = r_found;
    assign bus.center_x[gi*COORD_W +: COORD_W]    = r_cx;
    assign bus.center_y[gi*COORD_W +: COORD_W]    = r_cy;
    assign bus.width[gi*COORD_W +: COORD_W]       = r_w;
    assign bus.height[gi*COORD_W +: COORD_W]      = r_h;
    assign bus.pix_count[gi*CNT_W +: CNT_W]       = r_pix;
  end

  always_comb begin
    w_ovl = bus.in_pixel;
    for (int t = NUM_TARGETS - 1; t >= 0; t--) begin
      if (w_mark[t]) w_ovl = mark_colour(t);
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_out_valid   <= 1'b0;
      r_out_pixel   <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_eof;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= w_ovl;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_pixel   = r_out_pixel;
  assign bus.frame_valid = r_frame_valid;
endmodule

// File: doc/multi_color_tracker.md
Name: multi_color_tracker

Overview:
- Parametrised successor to the single-target green-blob tracker.
- Single-clock streaming stage on clock_50, placed after the camera CDC FIFO and before the VGA output FIFO.
- Classifies every pixel against NUM_TARGETS runtime-programmable colour rules and accumulates a bounding box and pixel count per target.
- Publishes per-target results at end of frame, and overlays a square marker on each target found in the previous frame onto the pass-through pixel stream.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, lines per frame.
- NUM_TARGETS, 2, number of independent colour targets (1..4).
- COORD_W, 12, coordinate and size width.
- CNT_W, 20, per-target matched-pixel counter width (saturating).
- MARK_RADIUS, 3, marker half-size in pixels.
- MIN_PIXELS, 16, minimum matched pixels for a target to be reported found.

Ports:
- clock_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  stage can accept a pixel.
- in_pixel  in  24  {R,G,B}, 8 bits each.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_pixel  out  24  pass-through pixel, with marker overlay applied.
- cfg_wr_en  in  1  write one target rule.
- cfg_idx  in  2  target index for the write.
- cfg_data  in  11  {enable[10], chan[9:8] (0=R, 1=G, 2=B), min[7:0]}.
- frame_valid  out  1  one-cycle pulse when results update.
- found  out  NUM_TARGETS  per-target found flag.
- center_x, center_y  out  NUM_TARGETS*COORD_W  flattened, target 0 in the LSBs.
- width, height  out  NUM_TARGETS*COORD_W  flattened bounding-box size.
- pix_count  out  NUM_TARGETS*CNT_W  flattened matched-pixel count.

Behaviour:
- Reset values: all outputs 0; coordinates (x,y)=(0,0); box accumulators min=all-ones, max=0; counts 0; all rule registers disabled (enable=0).
- Handshake:
  - in_ready = ~out_valid | out_ready.
  - A pixel is accepted when in_valid & in_ready.
  - Output register: one cycle of latency, holds steady while out_valid & ~out_ready.
  - No data loss and no duplication under any valid/ready pattern.
- Coordinates:
  - Advance only on acceptance; x wraps at WIDTH-1, y increments.
  - At (WIDTH-1, HEIGHT-1) both return to 0.
- Match rule for target t (enabled):
  - Dominant channel D = chan.
  - Match when D >= min and each other channel <= D>>1.
  - chan=3 never matches.
- On an accepted matching pixel, per target:
  - min_x/min_y/max_x/max_y update independently by unsigned compare.
  - count += 1, saturating at 2^CNT_W-1.
- End of frame (accepted pixel at (WIDTH-1, HEIGHT-1)), on the following cycle:
  - Accumulators including that final pixel are committed, and frame_valid pulses for exactly one cycle.
  - found[t] = enable & (count >= MIN_PIXELS).
  - If found: center = (min+max)>>1, computed at COORD_W+1 bits before the shift; size = max-min+1.
  - If not found: center, size and pix_count all 0.
  - Accumulators reset to their initial values for the next frame.
- Configuration:
  - cfg_wr_en writes a shadow register.
  - Shadow copies into the active rules on the first accepted pixel at (0,0), so a rule change never splits a frame.
  - Writes with cfg_idx >= NUM_TARGETS are ignored.
  - A write in the same cycle as the (0,0) acceptance is included in that frame.
- Overlay (uses the committed results of the previous frame):
  - A pixel is marked when found[t], |x-cx| <= MARK_RADIUS and |y-cy| <= MARK_RADIUS.
  - The comparison is done in signed COORD_W+1 arithmetic; there is no wrap-around near 0 or near the edges.
  - Marker colours: t0 = FF0000, t1 = 0000FF, t2 = FFFF00, t3 = FF00FF.
  - The lowest index wins on overlap.
  - Classification always uses the original pixel, never the overlaid one.
- Reset mid-frame:
  - Coordinates, accumulators, results and rules are cleared immediately.
  - The stream restarts at (0,0).
  - out_valid drops to 0 and no frame_valid pulse is produced.

Test Plan:
- WIDTH=8, HEIGHT=4, target0 = {1, G, 100}; 4x2 block of {40,200,40} at x=2..5, y=1..2, rest black -> frame_valid pulse; found0=1; center (3,1); size 4x2; pix_count0=8 with MIN_PIXELS=4.
- Same frame fed again with out_ready toggling 1,0,0,1 and random in_valid gaps -> out_pixel sequence equals the input sequence; markers FF0000 appear only within ±3 of (3,1), clipped at x=0 and y=0 with no wrap-around.
- Two targets (G and R rules) with overlapping 2x2 blobs -> independent boxes reported; overlay pixels in the overlap region show FF0000.
- Pixel {60,110,56}: 60 > 110>>1 = 55 -> no match; pixel {55,110,55} -> match; MIN_PIXELS not reached -> found=0 and all fields 0.
- cfg write disabling target0 at mid-frame pixel (3,2) -> current frame still reports found0=1; next frame reports found0=0.
- reset asserted at pixel (4,1) -> all outputs 0 within the reset cycle; first pixel after release is classified as (0,0); the next end of frame reports correctly.
